// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entry layout, buffer sizing and the address-width helper used by instr_fetch/fetch_buf.
package fetch_pkg;

    localparam int unsigned FETCH_BUF_DEPTH = 2;
    localparam int unsigned CNT_W           = $clog2(FETCH_BUF_DEPTH + 1);

    // Entry layout for the default configuration (32-bit words, 256-word memory).
    localparam int unsigned FETCH_DEF_IW = 32;
    localparam int unsigned FETCH_DEF_AW = 8;

    typedef struct packed {
        logic [FETCH_DEF_AW-1:0] pc;
        logic [FETCH_DEF_IW-1:0] instr;
    } fetch_entry_t;

    function automatic int unsigned fetch_addr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} FIFO between the instruction memory and decode.
// Synchronous flush empties the queue; push and pop may coincide at any occupancy.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned IW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [AW-1:0]    push_pc,
    input  logic [IW-1:0]    push_instr,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [AW-1:0]    head_pc,
    output logic [IW-1:0]    head_instr
);

    logic [AW-1:0]    pc_mem    [FETCH_BUF_DEPTH];
    logic [IW-1:0]    instr_mem [FETCH_BUF_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A full queue only accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((count_q != CNT_W'(FETCH_BUF_DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FETCH_BUF_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count      = count_q;
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, one-cycle memory read tracking, credit-gated issue and redirect flush.
// Returned words are queued in fetch_buf and offered to decode with valid/ready.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter  int unsigned INSTR_WIDTH = 32,
    parameter  int unsigned DEPTH       = 256,
    localparam int unsigned ADDR_W      = fetch_addr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic [ADDR_W-1:0]      imem_rd_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_W-1:0]      out_pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] req_pc_q;
    logic              inflight_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              pop;
    logic              issue;

    assign pop = out_valid && out_ready;

    // Slots already committed after this cycle's pop; the in-flight word needs one.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue     = fetch_en && !redirect_valid &&
                       (occupancy < (CNT_W+1)'(FETCH_BUF_DEPTH));

    assign pc_next = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else if (issue) begin
            pc_q       <= pc_next;
            req_pc_q   <= pc_q;
            inflight_q <= 1'b1;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    assign imem_rd_addr = pc_q;

    fetch_buf #(
        .AW (ADDR_W),
        .IW (INSTR_WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (inflight_q),
        .push_pc    (req_pc_q),
        .push_instr (imem_rd_data),
        .pop        (pop),
        .count      (count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

    assign out_valid = (count != '0);

endmodule
